// File: rtl/cache_axi_bridge_pkg.sv
// Shared constants, state encodings and helpers for the cache-to-AXI bridge.
// Used by both the top-level read path and the write channel sub-module.
package cache_axi_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_B    = 2'd2
  } w_state_t;

  // Any code other than TYPE_LINE is serviced as a single word.
  function automatic logic is_line(input logic [2:0] req_type);
    return req_type == TYPE_LINE;
  endfunction

endpackage

// File: rtl/cache_axi_wchan.sv
// Write buffer + write FSM: latches one cache write, drives AXI AW/W/B, exports buffer line for hazards.
// Latency: AW/W valid the cycle after wr_req&&wr_rdy; AW and W handshake independently.
// Backpressure: wr_rdy only in W_IDLE (state-derived); beats held until awready/wready; waits for bvalid.
module cache_axi_wchan
  import cache_axi_bridge_pkg::*;
#(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr_req,
  input  logic [2:0]                 wr_type,
  input  logic [31:0]                wr_addr,
  input  logic [3:0]                 wr_wstrb,
  input  logic [LINE_WORDS*32-1:0]   wr_data,
  output logic                       wr_rdy,
  output logic [3:0]                 awid,
  output logic [31:0]                awaddr,
  output logic [7:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [31:0]                wdata,
  output logic [3:0]                 wstrb,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic                       bvalid,
  output logic                       bready,
  output logic                       buf_valid,
  output logic [31-$clog2(LINE_WORDS*4):0] buf_line_addr
);

  localparam int             OFF       = $clog2(LINE_WORDS * 4);
  localparam int             CW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CW-1:0]  LAST_BEAT = CW'(LINE_WORDS - 1);

  w_state_t                  w_state, w_state_nxt;
  logic [31:0]               addr_q;
  logic                      line_q;
  logic [3:0]                strb_q;
  logic [LINE_WORDS*32-1:0]  data_q;
  logic                      aw_done, w_done;
  logic [CW-1:0]             cnt;
  logic                      aw_hs, w_hs;

  always_comb begin
    w_state_nxt = w_state;
    wr_rdy      = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    case (w_state)
      W_IDLE: begin
        wr_rdy = 1'b1;
        if (wr_req) w_state_nxt = W_SEND;
      end
      W_SEND: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        // Either channel may finish first; leave once both are complete this cycle or earlier.
        if ((aw_done || awready) && (w_done || (wready && wlast))) w_state_nxt = W_B;
      end
      W_B: begin
        bready = 1'b1;
        if (bvalid) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      addr_q  <= '0;
      line_q  <= 1'b0;
      strb_q  <= '0;
      data_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      cnt     <= '0;
    end else begin
      w_state <= w_state_nxt;
      if (w_state == W_IDLE && wr_req) begin
        addr_q  <= wr_addr;
        line_q  <= is_line(wr_type);
        strb_q  <= wr_wstrb;
        data_q  <= wr_data;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        cnt     <= '0;
      end else if (w_state == W_SEND) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs) begin
          if (wlast) w_done <= 1'b1;
          else       cnt    <= cnt + CW'(1);
        end
      end
    end
  end

  assign awid          = AXI_ID;
  assign awaddr        = {addr_q[31:2], 2'b00};
  assign awlen         = line_q ? 8'(LINE_WORDS - 1) : 8'd0;
  assign awsize        = AXI_SIZE_4B;
  assign awburst       = AXI_BURST_INCR;
  assign wdata         = line_q ? data_q[32*int'(cnt) +: 32] : data_q[31:0];
  assign wstrb         = line_q ? 4'hf : strb_q;
  assign wlast         = line_q ? (cnt == LAST_BEAT) : 1'b1;
  assign buf_valid     = (w_state != W_IDLE);
  assign buf_line_addr = addr_q[31:OFF];

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache miss responder to AXI4 master: line fills/writebacks and word accesses; optional bus_err via CACHE_AXI_RESP_CHECK_EN.
// Latency: AR/AW issue the cycle after acceptance; R data returns combinationally to the cache.
// Backpressure: rd_rdy/wr_rdy low while busy; rd_rdy also low when the read line hits the pending writeback.
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      rd_req,
  input  logic [2:0]                rd_type,
  input  logic [31:0]               rd_addr,
  output logic                      rd_rdy,
  output logic                      ret_valid,
  output logic                      ret_last,
  output logic [31:0]               ret_data,
  input  logic                      wr_req,
  input  logic [2:0]                wr_type,
  input  logic [31:0]               wr_addr,
  input  logic [3:0]                wr_wstrb,
  input  logic [LINE_WORDS*32-1:0]  wr_data,
  output logic                      wr_rdy,
  output logic [3:0]                arid,
  output logic [31:0]               araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [3:0]                rid,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [3:0]                awid,
  output logic [31:0]               awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [31:0]               wdata,
  output logic [3:0]                wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [3:0]                bid,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready
`ifdef CACHE_AXI_RESP_CHECK_EN
  ,
  output logic                      bus_err
`endif
);

  localparam int OFF = $clog2(LINE_WORDS * 4);

  r_state_t        r_state, r_state_nxt;
  logic [31:0]     rd_addr_q;
  logic            rd_line_q;
  logic            buf_valid;
  logic [31-OFF:0] buf_line_addr;
  logic            rd_hazard;

  // A refill must not overtake a writeback of the same line, including one accepted this cycle.
  assign rd_hazard = (buf_valid && (rd_addr[31:OFF] == buf_line_addr)) ||
                     (wr_req && wr_rdy && (rd_addr[31:OFF] == wr_addr[31:OFF]));

  always_comb begin
    r_state_nxt = r_state;
    rd_rdy      = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    case (r_state)
      R_IDLE: begin
        rd_rdy = !rd_hazard;
        if (rd_req && !rd_hazard) r_state_nxt = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= R_IDLE;
      rd_addr_q <= '0;
      rd_line_q <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      if (rd_req && rd_rdy) begin
        rd_addr_q <= rd_addr;
        rd_line_q <= is_line(rd_type);
      end
    end
  end

  assign arid      = AXI_ID;
  assign araddr    = {rd_addr_q[31:2], 2'b00};
  assign arlen     = rd_line_q ? 8'(LINE_WORDS - 1) : 8'd0;
  assign arsize    = AXI_SIZE_4B;
  assign arburst   = AXI_BURST_INCR;
  assign ret_valid = rready && rvalid;
  assign ret_last  = rready && rlast;
  assign ret_data  = rdata;

  cache_axi_wchan #(
    .LINE_WORDS (LINE_WORDS),
    .AXI_ID     (AXI_ID)
  ) u_wchan (
    .clk           (clk),
    .resetn        (resetn),
    .wr_req        (wr_req),
    .wr_type       (wr_type),
    .wr_addr       (wr_addr),
    .wr_wstrb      (wr_wstrb),
    .wr_data       (wr_data),
    .wr_rdy        (wr_rdy),
    .awid          (awid),
    .awaddr        (awaddr),
    .awlen         (awlen),
    .awsize        (awsize),
    .awburst       (awburst),
    .awvalid       (awvalid),
    .awready       (awready),
    .wdata         (wdata),
    .wstrb         (wstrb),
    .wlast         (wlast),
    .wvalid        (wvalid),
    .wready        (wready),
    .bvalid        (bvalid),
    .bready        (bready),
    .buf_valid     (buf_valid),
    .buf_line_addr (buf_line_addr)
  );

  logic unused_ids;
  assign unused_ids = ^{rid, bid};

`ifdef CACHE_AXI_RESP_CHECK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_err <= 1'b0;
    end else if ((rvalid && (rresp != AXI_RESP_OKAY)) || (bvalid && (bresp != AXI_RESP_OKAY))) begin
      bus_err <= 1'b1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};
`endif

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed + randomized bench for cache_axi_bridge with a transaction-level expectation model.
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         resetn;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [3:0]   arid, awid, rid, bid;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]   wstrb;
`ifdef CACHE_AXI_RESP_CHECK_EN
  logic         bus_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef CACHE_AXI_RESP_CHECK_EN
    , .bus_err(bus_err)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] pick_type(input int sel);
    logic [2:0] t;
    case (sel)
      0:       t = 3'b010;
      1:       t = 3'b100;
      default: t = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
    endcase
    return t;
  endfunction

  // Full read transaction: request, AR with ar_delay stalls, beats with random gaps.
  task automatic do_read(input logic [31:0] addr, input logic [2:0] typ, input int ar_delay,
                         input logic [127:0] rdat);
    int n;
    n = (typ == 3'b100) ? 4 : 1;
    rd_req = 1'b1; rd_addr = addr; rd_type = typ;
    #1;
    check("rd_rdy_idle", 128'(rd_rdy), 128'(1));
    step();
    rd_req = 1'b0;
    #1;
    check("rd_rdy_busy", 128'(rd_rdy), 128'(0));
    for (int c = 0; c <= ar_delay; c++) begin
      arready = (c == ar_delay);
      #1;
      check("arvalid_held", 128'(arvalid), 128'(1));
      check("araddr", 128'(araddr), 128'({addr[31:2], 2'b00}));
      check("arlen", 128'(arlen), 128'(n - 1));
      check("ar_id_size_burst", 128'({arid, arsize, arburst}), 128'({4'd0, 3'd2, 2'd1}));
      step();
    end
    arready = 1'b0;
    #1;
    check("arvalid_after_hs", 128'(arvalid), 128'(0));
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        rvalid = 1'b0;
        #1;
        check("ret_valid_gap", 128'(ret_valid), 128'(0));
        check("rready", 128'(rready), 128'(1));
        step();
      end
      rvalid = 1'b1; rdata = rdat[32*i +: 32]; rlast = (i == n - 1); rid = 4'($urandom);
      #1;
      check("ret_valid", 128'(ret_valid), 128'(1));
      check("ret_data", 128'(ret_data), 128'(rdat[32*i +: 32]));
      check("ret_last", 128'(ret_last), 128'(i == n - 1));
      step();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("rd_rdy_done", 128'(rd_rdy), 128'(1));
    check("rready_done", 128'(rready), 128'(0));
  endtask

  // Full write transaction. mode 0: W before AW, 1: AW before W, 2: random readies, 3: both ready.
  task automatic do_write(input logic [31:0] addr, input logic [2:0] typ, input logic [3:0] strb,
                          input logic [127:0] data, input int mode);
    int  n, bi, gap;
    bit  aw_seen, line;
    line = (typ == 3'b100);
    n    = line ? 4 : 1;
    wr_req = 1'b1; wr_addr = addr; wr_type = typ; wr_wstrb = strb; wr_data = data;
    #1;
    check("wr_rdy_idle", 128'(wr_rdy), 128'(1));
    step();
    wr_req = 1'b0;
    #1;
    check("wr_rdy_busy", 128'(wr_rdy), 128'(0));
    bi = 0; aw_seen = 1'b0;
    for (int cyc = 0; cyc < 40 && !(aw_seen && bi == n); cyc++) begin
      case (mode)
        0:       begin wready = 1'b1;    awready = (bi == n); end
        1:       begin awready = 1'b1;   wready = aw_seen;    end
        2:       begin awready = ($urandom_range(0, 3) != 0); wready = ($urandom_range(0, 3) != 0); end
        default: begin awready = 1'b1;   wready = 1'b1;       end
      endcase
      #1;
      check("awvalid", 128'(awvalid), 128'(!aw_seen));
      check("wvalid", 128'(wvalid), 128'(bi < n));
      if (!aw_seen) begin
        check("awaddr", 128'(awaddr), 128'({addr[31:2], 2'b00}));
        check("awlen", 128'(awlen), 128'(n - 1));
        check("aw_id_size_burst", 128'({awid, awsize, awburst}), 128'({4'd0, 3'd2, 2'd1}));
      end
      if (bi < n && wready) begin
        check("wdata", 128'(wdata), 128'(line ? data[32*bi +: 32] : data[31:0]));
        check("wstrb", 128'(wstrb), 128'(line ? 4'hf : strb));
        check("wlast", 128'(wlast), 128'(bi == n - 1));
        bi++;
      end
      if (!aw_seen && awready) aw_seen = 1'b1;
      step();
    end
    awready = 1'b0; wready = 1'b0;
    #1;
    check("w_complete", 128'({aw_seen, bi == n}), 128'(2'b11));
    check("aw_w_idle", 128'({awvalid, wvalid}), 128'(0));
    gap = $urandom_range(0, 3);
    for (int g = 0; g < gap; g++) begin
      check("wr_rdy_wait_b", 128'(wr_rdy), 128'(0));
      check("bready", 128'(bready), 128'(1));
      step();
    end
    bvalid = 1'b1; bid = 4'($urandom);
    #1;
    check("bready_hs", 128'(bready), 128'(1));
    step();
    bvalid = 1'b0;
    #1;
    check("wr_rdy_after_b", 128'(wr_rdy), 128'(1));
    check("bready_after_b", 128'(bready), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d, r;
    resetn = 1'b0;
    rd_req = 1'b0; rd_type = 3'b010; rd_addr = '0;
    wr_req = 1'b0; wr_type = 3'b010; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    bid = '0; bresp = '0; bvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valids", 128'({arvalid, awvalid, wvalid, ret_valid, rready, bready}), 128'(0));
    check("reset_rdys", 128'({rd_rdy, wr_rdy}), 128'(2'b11));
`ifdef CACHE_AXI_RESP_CHECK_EN
    check("reset_bus_err", 128'(bus_err), 128'(0));
`endif
    @(negedge clk);
    resetn = 1'b1;
    step();

    // Line read, 3-cycle arready stall, fixed data.
    do_read(32'h1c000040, 3'b100, 3, {32'h44, 32'h33, 32'h22, 32'h11});

    // Line write, W beats before AW.
    d = {$urandom, $urandom, $urandom, $urandom};
    do_write(32'h00000080, 3'b100, 4'h0, d, 0);

    // Uncached word write with partial strobes.
    do_write(32'hbfaf8004, 3'b010, 4'b0011, 128'h1234, 1);

    // Writeback to 0x100 pending blocks a read of the same line.
    wr_req = 1'b1; wr_addr = 32'h100; wr_type = 3'b100; wr_data = {$urandom, $urandom, $urandom, $urandom};
    step();
    wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 32'h108; rd_type = 3'b010;
    awready = 1'b1; wready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("hz_rd_rdy_send", 128'(rd_rdy), 128'(0));
      check("hz_arvalid_send", 128'(arvalid), 128'(0));
      step();
    end
    awready = 1'b0; wready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("hz_rd_rdy_b", 128'(rd_rdy), 128'(0));
      check("hz_bready", 128'(bready), 128'(1));
      step();
    end
    bvalid = 1'b1;
    #1;
    check("hz_rd_rdy_bvalid", 128'(rd_rdy), 128'(0));
    step();
    bvalid = 1'b0;
    #1;
    check("hz_rd_rdy_release", 128'(rd_rdy), 128'(1));
    step();
    rd_req = 1'b0;
    #1;
    check("hz_arvalid", 128'(arvalid), 128'(1));
    check("hz_araddr", 128'(araddr), 128'(32'h108));
    check("hz_arlen", 128'(arlen), 128'(0));
    arready = 1'b1;
    step();
    arready = 1'b0;
    r = 128'($urandom);
    rvalid = 1'b1; rlast = 1'b1; rdata = r[31:0];
    #1;
    check("hz_ret_data", 128'({ret_valid, ret_last, ret_data}), 128'({2'b11, r[31:0]}));
    step();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("hz_rd_rdy_end", 128'(rd_rdy), 128'(1));

    // Same-cycle hazard: write accepted now to the read's line masks rd_rdy.
    wr_req = 1'b1; wr_addr = 32'h400; wr_type = 3'b100;
    rd_req = 1'b1; rd_addr = 32'h404; rd_type = 3'b010;
    #1;
    check("same_cycle_hz", 128'({wr_rdy, rd_rdy}), 128'(2'b10));
    wr_req = 1'b0; rd_req = 1'b0;
    step();

    // Simultaneous line read 0x200 and line write 0x300.
    d = {$urandom, $urandom, $urandom, $urandom};
    r = {$urandom, $urandom, $urandom, $urandom};
    rd_req = 1'b1; rd_addr = 32'h200; rd_type = 3'b100;
    wr_req = 1'b1; wr_addr = 32'h300; wr_type = 3'b100; wr_data = d;
    #1;
    check("sim_both_rdy", 128'({rd_rdy, wr_rdy}), 128'(2'b11));
    step();
    rd_req = 1'b0; wr_req = 1'b0;
    #1;
    check("sim_ar_aw_valid", 128'({arvalid, awvalid, wvalid}), 128'(3'b111));
    check("sim_addrs", 128'({araddr, awaddr}), 128'({32'h200, 32'h300}));
    check("sim_wdata0", 128'(wdata), 128'(d[31:0]));
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    step();
    arready = 1'b0; awready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wready = (i < 3);
      rvalid = 1'b1; rdata = r[32*i +: 32]; rlast = (i == 3);
      #1;
      check("sim_ret", 128'({ret_valid, ret_last, ret_data}), 128'({1'b1, i == 3, r[32*i +: 32]}));
      if (i < 3) check("sim_wbeat", 128'({wlast, wdata}), 128'({i == 2, d[32*(i+1) +: 32]}));
      step();
    end
    wready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("sim_b_wait", 128'({bready, rd_rdy, wr_rdy}), 128'(3'b110));
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    #1;
    check("sim_wr_rdy_end", 128'(wr_rdy), 128'(1));

    // Reset asserted mid read burst with a write also in flight.
    rd_req = 1'b1; rd_addr = 32'h500; rd_type = 3'b100;
    wr_req = 1'b1; wr_addr = 32'h600; wr_type = 3'b010; wr_data = 128'($urandom); wr_wstrb = 4'hf;
    step();
    rd_req = 1'b0; wr_req = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = $urandom; rlast = 1'b0;
`ifdef CACHE_AXI_RESP_CHECK_EN
    rresp = 2'b10;
`endif
    step();
`ifdef CACHE_AXI_RESP_CHECK_EN
    rresp = 2'b00;
    check("bus_err_set", 128'(bus_err), 128'(1));
`endif
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_valids", 128'({arvalid, awvalid, wvalid, ret_valid, rready, bready}), 128'(0));
`ifdef CACHE_AXI_RESP_CHECK_EN
    check("async_reset_bus_err", 128'(bus_err), 128'(0));
`endif
    rvalid = 1'b0;
    step();
    step();
    resetn = 1'b1;
    #1;
    check("post_reset_rdys", 128'({rd_rdy, wr_rdy}), 128'(2'b11));
    step();

    // Randomized traffic, one write then one read per iteration.
    for (int k = 0; k < 12; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      do_write($urandom, pick_type($urandom_range(0, 2)), 4'($urandom), d, k % 4);
      r = {$urandom, $urandom, $urandom, $urandom};
      do_read($urandom, pick_type($urandom_range(0, 2)), $urandom_range(0, 3), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
